laser_manager: RTL and testbench

//   Downstream of plane_controller: turns the laser_attack level and plane_h into a pool of
//   in-flight laser shots. Spawns a shot on each accepted press, moves shots upward once per

---
 rtl/laser_manager.sv | 123 ++++++++++++
 tb/tb_laser_manager.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_manager.sv
// Laser shot pool: spawns shots on accepted fire presses, moves them up each frame,
// and retires them at the screen top, on a collision clear, or outside the playing state.
module laser_manager #(
  parameter int N_SLOTS  = 4,
  parameter int SPAWN_V  = 440,
  parameter int H_OFFSET = 12,
  parameter int TOP_V    = 8,
  parameter int SPEED    = 6,
  parameter int COOLDOWN = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            state,
  input  logic                  frame_tick,
  input  logic [9:0]            plane_h,
  input  logic                  laser_attack,
  input  logic [N_SLOTS-1:0]    hit_clear,
  output logic [N_SLOTS-1:0]    laser_valid,
  output logic [10*N_SLOTS-1:0] laser_h,
  output logic [10*N_SLOTS-1:0] laser_v,
  output logic                  fire_pulse
);

  localparam logic [9:0] SPAWN_V_L  = 10'(SPAWN_V);
  localparam logic [9:0] H_OFFSET_L = 10'(H_OFFSET);
  localparam logic [9:0] SPEED_L    = 10'(SPEED);
  // A shot below this row cannot take a full step without crossing TOP_V.
  localparam logic [9:0] RETIRE_V   = 10'(TOP_V + SPEED);
  localparam logic [7:0] COOLDOWN_L = 8'(COOLDOWN);

  typedef enum logic {IDLE, ACTIVE} slot_state_e;

  slot_state_e slot_q [N_SLOTS];
  slot_state_e slot_d [N_SLOTS];
  logic [9:0]  h_q    [N_SLOTS];
  logic [9:0]  h_d    [N_SLOTS];
  logic [9:0]  v_q    [N_SLOTS];
  logic [9:0]  v_d    [N_SLOTS];
  logic [7:0]  cool_q, cool_d;
  logic        attack_q;
  logic        fire_q;

  logic               playing;
  logic               fire_req;
  logic               spawn;
  logic [N_SLOTS-1:0] free;
  logic [N_SLOTS-1:0] target_oh;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    playing  = (state == 2'd1);
    fire_req = laser_attack & ~attack_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      free[i] = (slot_q[i] == IDLE);
    end
    // Isolate the lowest set bit: lowest-index idle slot, sampled before any clear.
    target_oh = free & (~free + 1'b1);
    spawn     = playing & fire_req & (cool_q == 8'd0) & (|free);

    cool_d = cool_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      h_d[i]    = h_q[i];
      v_d[i]    = v_q[i];
    end

    if (!playing) begin
      for (int i = 0; i < N_SLOTS; i++) slot_d[i] = IDLE;
      cool_d = 8'd0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (slot_q[i] == ACTIVE) begin
          if (hit_clear[i]) begin
            slot_d[i] = IDLE;
          end else if (frame_tick) begin
            if (v_q[i] < RETIRE_V) slot_d[i] = IDLE;
            else                   v_d[i] = v_q[i] - SPEED_L;
          end
        end else if (spawn && target_oh[i]) begin
          slot_d[i] = ACTIVE;
          h_d[i]    = plane_h + H_OFFSET_L;
          v_d[i]    = SPAWN_V_L;
        end
      end
      if (spawn)                            cool_d = COOLDOWN_L;
      else if (frame_tick && cool_q != 8'd0) cool_d = cool_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slot arrays are flops, not RAM, and must all clear on reset.
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_q[i] <= IDLE;
        h_q[i]    <= '0;
        v_q[i]    <= '0;
      end
      cool_q   <= '0;
      attack_q <= 1'b0;
      fire_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
        h_q[i]    <= h_d[i];
        v_q[i]    <= v_d[i];
      end
      cool_q   <= cool_d;
      attack_q <= laser_attack;
      fire_q   <= spawn;
    end
  end

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      laser_valid[i]     = (slot_q[i] == ACTIVE);
      laser_h[10*i +: 10] = h_q[i];
      laser_v[10*i +: 10] = v_q[i];
    end
    fire_pulse = fire_q;
  end

endmodule

// File: tb/tb_laser_manager.sv
// Bench for laser_manager: directed scenarios plus random play, scoreboarded against
// a shot-list model; a monitor compares every cycle's outputs against queued expectations.
module tb_laser_manager;

  localparam int N = 4;
  localparam int SPAWN_V = 440, H_OFFSET = 12, TOP_V = 8, SPEED = 6, COOLDOWN = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    state = 2'd0;
  logic          frame_tick = 1'b0;
  logic [9:0]    plane_h = 10'd0;
  logic          laser_attack = 1'b0;
  logic [N-1:0]  hit_clear = '0;
  logic [N-1:0]  laser_valid;
  logic [10*N-1:0] laser_h, laser_v;
  logic          fire_pulse;

  laser_manager dut (
    .clk(clk), .rst_n(rst_n), .state(state), .frame_tick(frame_tick),
    .plane_h(plane_h), .laser_attack(laser_attack), .hit_clear(hit_clear),
    .laser_valid(laser_valid), .laser_h(laser_h), .laser_v(laser_v),
    .fire_pulse(fire_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    valid;
    logic [10*N-1:0] h;
    logic [10*N-1:0] v;
    logic            fire;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  bit    mon_on = 1'b0;

  // Reference model: a list of shots with live flag and position.
  bit m_live[N];
  int m_h[N], m_v[N];
  int m_cd;
  bit m_prev, m_fire;
  logic [9:0] cur_ph = 10'd145;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [9:0] get_h(int i); return laser_h[10*i +: 10]; endfunction
  function automatic logic [9:0] get_v(int i); return laser_v[10*i +: 10]; endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.h = '0; s.v = '0;
    for (int i = 0; i < N; i++) begin
      s.valid[i] = m_live[i];
      s.h[10*i +: 10] = 10'(m_h[i]);
      s.v[10*i +: 10] = 10'(m_v[i]);
    end
    s.fire = m_fire;
    return s;
  endfunction

  task automatic model_step(input logic [1:0] st, input logic ft, input logic [9:0] ph,
                            input logic atk, input logic [N-1:0] hc);
    bit press;
    int slot;
    press  = atk && !m_prev;
    m_prev = atk;
    m_fire = 1'b0;
    if (st != 2'd1) begin
      for (int i = 0; i < N; i++) m_live[i] = 1'b0;
      m_cd = 0;
      return;
    end
    slot = -1;
    for (int i = 0; i < N; i++) if (!m_live[i] && slot < 0) slot = i;
    for (int i = 0; i < N; i++) begin
      if (m_live[i]) begin
        if (hc[i]) m_live[i] = 1'b0;
        else if (ft) begin
          if (m_v[i] - SPEED < TOP_V) m_live[i] = 1'b0;
          else m_v[i] -= SPEED;
        end
      end
    end
    if (press && m_cd == 0 && slot >= 0) begin
      m_live[slot] = 1'b1;
      m_h[slot] = (int'(ph) + H_OFFSET) % 1024;
      m_v[slot] = SPAWN_V;
      m_cd = COOLDOWN;
      m_fire = 1'b1;
    end else if (ft && m_cd > 0) begin
      m_cd--;
    end
  endtask

  // Called at a negedge; returns at the next negedge with the DUT updated.
  task automatic step(input logic [1:0] st, input logic ft, input logic [9:0] ph,
                      input logic atk, input logic [N-1:0] hc);
    state = st; frame_tick = ft; plane_h = ph; laser_attack = atk; hit_clear = hc;
    model_step(st, ft, ph, atk, hc);
    exp_q.push_back(model_snap());
    @(negedge clk);
  endtask

  task automatic play(input logic ft, input logic atk);
    step(2'd1, ft, cur_ph, atk, '0);
  endtask

  task automatic shoot();
    play(1'b0, 1'b1);
    play(1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) play(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset", {laser_valid, laser_h, laser_v, fire_pulse}, '0);
    for (int i = 0; i < N; i++) begin m_live[i] = 0; m_h[i] = 0; m_v[i] = 0; end
    m_cd = 0; m_prev = 0; m_fire = 0;
    exp_q.push_back(model_snap());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: outputs are presented every cycle; compare live-slot positions only.
  initial begin
    snap_t e;
    logic [10*N-1:0] mask;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < N; i++) mask[10*i +: 10] = {10{e.valid[i]}};
          check("snapshot", {laser_valid, laser_h & mask, laser_v & mask, fire_pulse},
                            {e.valid, e.h & mask, e.v & mask, e.fire});
        end
      end
    end
  end

  initial begin
    int fires;
    @(negedge clk);
    mon_on = 1'b1;
    do_reset();
    check("reset_valid", laser_valid, '0);

    // Press at plane_h=145 -> slot0 at column 157, row 440, single fire pulse.
    cur_ph = 10'd145;
    play(1'b0, 1'b0);
    play(1'b0, 1'b1);
    check("t1_valid", laser_valid, 4'b0001);
    check("t1_h", get_h(0), 10'd157);
    check("t1_v", get_v(0), 10'd440);
    check("t1_fire", fire_pulse, 1'b1);
    fires = 0;
    for (int k = 0; k < 50; k++) begin play(1'b0, 1'b1); fires += int'(fire_pulse); end
    check("t2_hold_one_spawn", 32'(fires), 32'd0);
    play(1'b0, 1'b0);
    ticks(9);
    play(1'b0, 1'b1);
    check("t2_cooldown_refuse", {laser_valid, fire_pulse}, {4'b0001, 1'b0});
    play(1'b0, 1'b0);
    ticks(1);
    play(1'b0, 1'b1);
    check("t2_after_cooldown", {laser_valid, fire_pulse}, {4'b0011, 1'b1});
    check("t2_slot1_v", get_v(1), 10'd440);

    // Single shot flight to the top.
    do_reset();
    shoot();
    ticks(71);
    check("t3_v_after71", get_v(0), 10'd14);
    ticks(1);
    check("t3_v_after72", {laser_valid[0], get_v(0)}, {1'b1, 10'd8});
    ticks(1);
    check("t3_retired", laser_valid, '0);

    // Fill the pool, overflow, clear+press collision, then reuse slot2.
    do_reset();
    cur_ph = 10'd300;
    for (int k = 0; k < 4; k++) begin shoot(); ticks(10); end
    play(1'b0, 1'b1);
    check("t4_pool_full", {laser_valid, fire_pulse}, {4'b1111, 1'b0});
    play(1'b0, 1'b0);
    step(2'd1, 1'b0, cur_ph, 1'b1, 4'b0100);
    check("t4_clear_press", {laser_valid, fire_pulse}, {4'b1011, 1'b0});
    play(1'b0, 1'b0);
    play(1'b0, 1'b1);
    check("t4_reuse_slot2", {laser_valid, fire_pulse, get_v(2)}, {4'b1111, 1'b1, 10'd440});
    play(1'b0, 1'b0);

    // Spawn coincident with frame_tick.
    do_reset();
    shoot();
    ticks(10);
    step(2'd1, 1'b1, cur_ph, 1'b1, '0);
    check("t5_new_unmoved", get_v(1), 10'd440);
    check("t5_old_moved", get_v(0), 10'd374);
    play(1'b0, 1'b0);
    ticks(9);
    play(1'b0, 1'b1);
    check("t5_cooldown_loaded", fire_pulse, 1'b0);
    play(1'b0, 1'b0);
    ticks(1);
    play(1'b0, 1'b1);
    check("t5_cooldown_done", fire_pulse, 1'b1);

    // Leaving play clears shots; a key held into play does not fire.
    step(2'd2, 1'b0, cur_ph, 1'b0, '0);
    check("t6_gameover_clear", laser_valid, '0);
    step(2'd0, 1'b0, cur_ph, 1'b1, '0);
    play(1'b0, 1'b1);
    check("t6_held_no_fire", {laser_valid, fire_pulse}, {4'b0000, 1'b0});
    play(1'b0, 1'b0);
    play(1'b0, 1'b1);
    check("t6_repress_fires", fire_pulse, 1'b1);
    ticks(3);
    do_reset();

    // Random play against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [1:0] st;
      logic atk;
      logic [N-1:0] hc;
      st  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      atk = ($urandom_range(0, 2) == 0) ? ~laser_attack : laser_attack;
      hc  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) cur_ph = 10'($urandom_range(0, 1000));
      step(st, 1'($urandom_range(0, 3) == 0), cur_ph, atk, hc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
